// File: rtl/seg_display_monitor.sv
// ---------------------------------------------------------------------------
// seg_display_monitor
//
// Receive side of the stopwatch's two-digit multiplexed 7-segment driver.
// Samples the seg/an bus on sample_en, debounces each digit independently,
// decodes committed patterns back to BCD, counts illegal patterns and
// flags a multiplexer that has stopped toggling an.
//
// Handshake: sample_en is a one-cycle strobe with no back-pressure. seg/an
// are only examined in cycles where sample_en=1. Every other cycle holds
// state, and the pulse outputs return to 0.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   sample_en    one-clk sample strobe
//   seg[6:0]     {g,f,e,d,c,b,a}, active-low segments
//   an           digit select (0 = ones, 1 = tens)
//   digit0/1     committed ones/tens digit (BCD, 4'hF = blank)
//   value_valid  both digits committed since last reset/stall
//   updated      pulse: committed digit changed while locked
//   seg_error    pulse: illegal pattern committed
//   err_count    saturating count of illegal commits
//   mux_stall    an has not toggled for TIMEOUT_TICKS samples
//   fsm_state    debug view of the lock FSM (0 idle, 1 half, 2 locked)
//   value_bin    (only with SEG_DISPLAY_MONITOR_BIN_EN) 10*digit1+digit0
//
// Optional feature macro: SEG_DISPLAY_MONITOR_BIN_EN
// ---------------------------------------------------------------------------
module seg_display_monitor #(
    parameter int STABLE_SAMPLES = 2,
    parameter int TIMEOUT_TICKS  = 8,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [6:0]           seg,
    input  logic                 an,
    output logic [3:0]           digit0,
    output logic [3:0]           digit1,
    output logic                 value_valid,
    output logic                 updated,
    output logic                 seg_error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 mux_stall,
    output logic [1:0]           fsm_state
`ifdef SEG_DISPLAY_MONITOR_BIN_EN
    ,
    output logic [6:0]           value_bin
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALF   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] STABLE_4  = 4'(STABLE_SAMPLES);
    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT_TICKS);

    state_t     state_q, state_d;
    logic [6:0] cand [0:1];
    logic [3:0] cnt  [0:1];
    logic [1:0] have;
    logic       prev_an;
    logic [7:0] stall_cnt;

    logic [6:0] cur_cand;
    logic [3:0] cur_cnt;
    logic [3:0] next_cnt;
    logic       match;
    logic       commit;
    logic       toggle;
    logic       stall_hit;
    logic       pat_legal;
    logic [3:0] pat_digit;
    logic       legal_commit;
    logic       illegal_commit;
    logic [3:0] held_digit;
    logic       other_have;

    // Returns {legal, bcd}. Blank decodes to 4'hF and counts as legal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h7F:   decode = 5'h1F;
            default: decode = 5'h0F;
        endcase
    endfunction

    assign cur_cand = cand[an];
    assign cur_cnt  = cnt[an];
    assign match    = (seg == cur_cand);

    // Run length saturates at STABLE_SAMPLES; a new pattern restarts at 1.
    assign next_cnt = !match               ? 4'd1 :
                      (cur_cnt == STABLE_4) ? cur_cnt : cur_cnt + 4'd1;

    // Commit only on the sample that reaches the threshold, not while the
    // count sits saturated.
    assign commit = sample_en && (next_cnt == STABLE_4) &&
                    !(match && (cur_cnt == STABLE_4));

    assign toggle    = (an != prev_an);
    assign stall_hit = sample_en && !toggle && (stall_cnt == TIMEOUT_8 - 8'd1);

    assign {pat_legal, pat_digit} = decode(seg);
    assign legal_commit   = commit && pat_legal;
    assign illegal_commit = commit && !pat_legal;
    assign held_digit     = an ? digit1 : digit0;
    assign other_have     = an ? have[0] : have[1];

    // Datapath: filter, digits, stall watchdog, error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand[0]   <= 7'h7F;
            cand[1]   <= 7'h7F;
            cnt[0]    <= 4'd0;
            cnt[1]    <= 4'd0;
            have      <= 2'b00;
            prev_an   <= 1'b0;
            stall_cnt <= 8'd0;
            mux_stall <= 1'b0;
            digit0    <= 4'hF;
            digit1    <= 4'hF;
            err_count <= '0;
            seg_error <= 1'b0;
            updated   <= 1'b0;
        end else begin
            seg_error <= illegal_commit;
            // A stall on the same sample drops the lock, so no update pulse.
            updated   <= legal_commit && (state_q == LOCKED) && !stall_hit &&
                         (pat_digit != held_digit);
            if (sample_en) begin
                cand[an] <= seg;
                cnt[an]  <= next_cnt;
                prev_an  <= an;
                if (toggle) begin
                    stall_cnt <= 8'd0;
                    mux_stall <= 1'b0;
                end else if (stall_cnt != TIMEOUT_8) begin
                    stall_cnt <= stall_cnt + 8'd1;
                end
                if (stall_hit) begin
                    mux_stall <= 1'b1;
                    cnt[0]    <= 4'd0;
                    cnt[1]    <= 4'd0;
                end
                if (legal_commit) begin
                    if (an) digit1 <= pat_digit;
                    else    digit0 <= pat_digit;
                end
                if (stall_hit)
                    have <= 2'b00;
                else if (legal_commit)
                    have[an] <= 1'b1;
                if (illegal_commit && !(&err_count))
                    err_count <= err_count + 1'b1;
            end
        end
    end

    // Lock FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Lock FSM: next state. A stall overrides any commit on the same sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (legal_commit) state_d = HALF;
            HALF:    if (legal_commit && other_have) state_d = LOCKED;
            LOCKED:  state_d = LOCKED;
            default: state_d = IDLE;
        endcase
        if (stall_hit) state_d = IDLE;
    end

    // Lock FSM: outputs.
    always_comb begin
        value_valid = (state_q == LOCKED);
        fsm_state   = state_q;
    end

`ifdef SEG_DISPLAY_MONITOR_BIN_EN
    logic [3:0] d0_bin, d1_bin;
    assign d0_bin = (digit0 == 4'hF) ? 4'd0 : digit0;
    assign d1_bin = (digit1 == 4'hF) ? 4'd0 : digit1;

    // Follows the digits one clk later, frozen while not locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value_bin <= 7'd0;
        else if (value_valid)
            value_bin <= ({3'b000, d1_bin} * 7'd10) + {3'b000, d0_bin};
    end
`endif

endmodule

// File: tb/tb_seg_display_monitor.sv
module tb_seg_display_monitor;

  localparam int S  = 2;
  localparam int T  = 8;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_en = 1'b0;
  logic [6:0]    seg = 7'h7F;
  logic          an = 1'b0;
  logic [3:0]    digit0, digit1;
  logic          value_valid, updated, seg_error, mux_stall;
  logic [EW-1:0] err_count;
  logic [1:0]    fsm_state;
`ifdef SEG_DISPLAY_MONITOR_BIN_EN
  logic [6:0]    value_bin;
`endif

  always #5 clk = ~clk;

  seg_display_monitor #(
    .STABLE_SAMPLES(S),
    .TIMEOUT_TICKS(T),
    .ERR_CNT_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_en(sample_en),
    .seg(seg),
    .an(an),
    .digit0(digit0),
    .digit1(digit1),
    .value_valid(value_valid),
    .updated(updated),
    .seg_error(seg_error),
    .err_count(err_count),
    .mux_stall(mux_stall),
    .fsm_state(fsm_state)
`ifdef SEG_DISPLAY_MONITOR_BIN_EN
    ,
    .value_bin(value_bin)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Display-level view: the run length of the pattern seen on each digit,
  // the number of samples since an last changed, and what has been shown.
  logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] run_pat [2];
  int         run_len [2];
  int         since_toggle;
  logic       last_an;
  int         shown [2];
  bit         seen [2];
  bit         m_upd, m_err, m_stall;
  int         m_errcnt;
  int         m_bin;

  function automatic int pat_value(input logic [6:0] s);
    if (s == 7'h7F) return 15;
    for (int i = 0; i < 10; i++) if (pats[i] == s) return i;
    return -1;
  endfunction

  function automatic bit m_valid();
    return seen[0] && seen[1];
  endfunction

  function automatic int as_num(input int d);
    return (d == 15) ? 0 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run_pat[i] = 7'h7F; run_len[i] = 0; shown[i] = 15; seen[i] = 0;
    end
    since_toggle = 0; last_an = 0;
    m_upd = 0; m_err = 0; m_stall = 0; m_errcnt = 0; m_bin = 0;
  endtask

  task automatic model_idle();
    if (m_valid()) m_bin = as_num(shown[1]) * 10 + as_num(shown[0]);
    m_upd = 0; m_err = 0;
  endtask

  task automatic model_sample(input logic [6:0] s, input logic a);
    int  x, v;
    bit  tog, stall_now, was_valid;
    model_idle();
    was_valid = m_valid();
    x = a ? 1 : 0;
    tog = (a != last_an);
    last_an = a;
    since_toggle = tog ? 0 : since_toggle + 1;
    stall_now = !tog && (since_toggle == T);
    if (s == run_pat[x]) run_len[x]++;
    else begin
      run_pat[x] = s; run_len[x] = 1;
    end
    if (run_len[x] == S) begin
      v = pat_value(s);
      if (v >= 0) begin
        m_upd = was_valid && !stall_now && (v != shown[x]);
        shown[x] = v;
        seen[x] = 1;
      end else begin
        m_err = 1;
        if (m_errcnt < ERR_MAX) m_errcnt++;
      end
    end
    if (tog) m_stall = 0;
    if (stall_now) begin
      m_stall = 1; run_len[0] = 0; run_len[1] = 0; seen[0] = 0; seen[1] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digit0"}, digit0, shown[0]);
    check({tag, ".digit1"}, digit1, shown[1]);
    check({tag, ".value_valid"}, value_valid, m_valid());
    check({tag, ".updated"}, updated, m_upd);
    check({tag, ".seg_error"}, seg_error, m_err);
    check({tag, ".err_count"}, err_count, m_errcnt);
    check({tag, ".mux_stall"}, mux_stall, m_stall);
    check({tag, ".fsm_state"}, fsm_state, int'(seen[0]) + int'(seen[1]));
`ifdef SEG_DISPLAY_MONITOR_BIN_EN
    check({tag, ".value_bin"}, value_bin, m_bin);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(negedge clk);
    model_idle();
    check_all("idle");
  endtask

  task automatic smp(input logic [6:0] s, input logic a);
    seg = s; an = a; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    model_sample(s, a);
    check_all("smp");
    repeat ($urandom_range(0, 1)) idle_cycle();
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    sample_en = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_36();
    smp(7'h02, 0); smp(7'h30, 1); smp(7'h02, 0); smp(7'h30, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] cur [2];
    logic       a;
    logic [6:0] p;

    model_reset();
    apply_reset();

    // Basic lock onto "36".
    lock_36();
    check("lock.digit0", digit0, 6);
    check("lock.digit1", digit1, 3);
    check("lock.valid", value_valid, 1);

    // One-sample glitch is rejected; a two-sample change commits.
    smp(7'h10, 0); smp(7'h30, 1); smp(7'h02, 0); smp(7'h30, 1);
    check("glitch.digit0", digit0, 6);
    smp(7'h10, 0); smp(7'h30, 1);
    seg = 7'h10; an = 0; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    model_sample(7'h10, 0);
    check_all("chg");
    check("chg.updated", updated, 1);
    check("chg.digit0", digit0, 9);
    idle_cycle();
    check("chg.pulse_end", updated, 0);

    // Illegal pattern, then saturate the error counter.
    smp(7'h55, 0); smp(7'h30, 1); smp(7'h55, 0);
    check("illegal.err_count", err_count, 1);
    check("illegal.digit0", digit0, 9);
    for (int i = 0; i < 299; i++) begin
      p = (i % 2 == 0) ? 7'h54 : 7'h55;
      smp(p, 0); smp(7'h30, 1); smp(p, 0); smp(7'h30, 1);
    end
    check("sat.err_count", err_count, ERR_MAX);

    // Mux stall: an held at 1, then recovery.
    lock_36();
    for (int i = 0; i < T; i++) smp(7'h30, 1);
    check("stall.mux_stall", mux_stall, 1);
    check("stall.valid", value_valid, 0);
    smp(7'h02, 0);
    check("unstall.mux_stall", mux_stall, 0);
    smp(7'h30, 1); smp(7'h02, 0); smp(7'h30, 1);
    check("relock.valid", value_valid, 1);

    // Reset mid-traffic, then relock.
    smp(7'h19, 0);
    apply_reset();
    lock_36();
    check("post_reset.valid", value_valid, 1);

`ifdef SEG_DISPLAY_MONITOR_BIN_EN
    smp(7'h10, 0); smp(7'h10, 1); smp(7'h10, 0); smp(7'h10, 1);
    idle_cycle();
    check("bin.99", value_bin, 99);
    smp(7'h10, 0); smp(7'h7F, 1); smp(7'h10, 0); smp(7'h7F, 1);
    idle_cycle();
    check("bin.9", value_bin, 9);
`endif

    // Randomized traffic: mostly alternating an, digits that change now and
    // then, occasional glitches, illegal patterns and repeated an.
    cur[0] = 7'h40; cur[1] = 7'h40; a = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      if ($urandom_range(0, 15) != 0) a = ~a;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 9) < 8) begin
          int k;
          k = $urandom_range(0, 10);
          cur[a] = (k == 10) ? 7'h7F : pats[k];
        end else begin
          cur[a] = 7'($urandom);
        end
      end
      if ($urandom_range(0, 9) == 0) smp(7'($urandom), a);
      else smp(cur[a], a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_display_monitor.md
Name: seg_display_monitor

Overview:
- Receive-side counterpart to the stopwatch's multiplexed two-digit 7-segment driver.
- Samples the time-multiplexed seg/an bus and reconstructs the two displayed BCD digits.
- Filters transients, flags illegal segment patterns, and detects a stalled multiplexer.
- Used for on-chip self-check and as the scoreboard front end in system benches.

Parameters:
STABLE_SAMPLES, 2, consecutive identical samples of a digit required before commit (1..15)
TIMEOUT_TICKS, 8, sample ticks without an change before declaring a mux stall (2..255)
ERR_CNT_W, 8, width of the saturating illegal-pattern counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_en  in  1  one-clk-wide sample strobe (500 Hz tick domain-aligned to clk)
seg  in  7  {g,f,e,d,c,b,a}, active-low segments
an  in  1  digit select: 0 = ones digit on seg, 1 = tens digit on seg
digit0  out  4  committed ones digit (BCD, 4'hF = blank)
digit1  out  4  committed tens digit (BCD, 4'hF = blank)
value_valid  out  1  both digits committed since last reset/stall
updated  out  1  one-clk pulse when a committed digit changes while value_valid
seg_error  out  1  one-clk pulse on commit of an illegal pattern
err_count  out  ERR_CNT_W  saturating count of illegal commits
mux_stall  out  1  level: an has not toggled for TIMEOUT_TICKS sample ticks

Behaviour:
- Reset: digit0=digit1=4'hF, value_valid=0, updated=0, seg_error=0, err_count=0, mux_stall=0, FSM=IDLE, candidates=7'h7F, match counts=0, stall counter=0.
- seg/an are only examined in clk cycles with sample_en=1; all other cycles hold state (pulses return to 0).
- Legal patterns (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 7F = blank, decodes to 4'hF.
  - Any other pattern is illegal.
- Per-digit filter (x = an):
  - seg == cand[x]: cnt[x] increments, saturating at STABLE_SAMPLES.
  - seg != cand[x]: cand[x] <= seg, cnt[x] <= 1.
  - Commit when cnt[x] reaches STABLE_SAMPLES on this sample; the saturated hold does not re-commit.
- Commit of a legal pattern: digitx updates at the edge ending the sample_en cycle (latency 1 clk).
- Commit of an illegal pattern: digitx holds, seg_error pulses, err_count += 1 (saturates at all-ones).
- FSM:
  - IDLE -> HALF on the first legal commit of either digit.
  - HALF -> LOCKED once both digits hold legal commits.
  - LOCKED: value_valid=1.
  - updated pulses on a legal commit whose value differs from the held digit; no pulse on the HALF->LOCKED entry itself.
- Stall detection:
  - Stall counter clears whenever sampled an differs from the previous sampled an; otherwise it increments.
  - On reaching TIMEOUT_TICKS: mux_stall=1, FSM -> IDLE, value_valid=0, digits hold last values, cnt[] cleared.
  - mux_stall clears on the next an toggle.
- Simultaneous events: an illegal commit and a stall on the same sample both take effect (seg_error pulses, FSM enters IDLE).
- Reset mid-operation returns every register to its reset value immediately, independent of clk.

Optional Feature:
- Macro: SEG_DISPLAY_MONITOR_BIN_EN.
- Defined: adds output value_bin[6:0] = 10*digit1 + digit0, registered, valid 1 clk after any digit update. Blank digits count as 0. Holds its value while value_valid=0.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Reset, then alternate an=0/1 each tick with ones=0x02 ("6") and tens=0x30 ("3"), STABLE_SAMPLES=2 -> digit0=6, digit1=3, value_valid=1 after the 4th sample, updated stays 0.
- From locked 36, drive ones=0x10 ("9") for one sample, then back to 0x02 -> no change, no updated pulse; hold 0x10 for two samples instead -> digit0=9, single updated pulse.
- Drive ones pattern 0x55 for 2 samples -> seg_error pulses once, err_count=1, digit0 unchanged; repeat 300 times with ERR_CNT_W=8 -> err_count=255.
- Hold an=1 for 8 sample ticks -> mux_stall=1, value_valid=0 on the 8th; toggle an -> mux_stall=0, relock after 2 samples per digit.
- Assert reset mid-sequence between clk edges -> all outputs at reset values immediately; resume traffic -> relock as in scenario 1.
- With SEG_DISPLAY_MONITOR_BIN_EN: display "99" then tens blank (0x7F) -> value_bin=99, then 9.
